// File: rtl/mig2_pkg.sv
// Shared widths and types for the Mig2 instruction-fetch front end.
// Constants are the default build; modules re-derive widths from their own parameters.
package mig2_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_SIZE  = 4;
  localparam int DEF_DATA_WIDTH = DEF_DATA_SIZE * 8;
  localparam int DEF_WORD_LSB   = $clog2(DEF_DATA_SIZE);

  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] insn_t;

  typedef struct packed {
    addr_t pc;
    insn_t insn;
  } fetch_entry_t;

endpackage

// File: rtl/mig2_fetch_unit_if.sv
// Fetch-unit bus bundle: memory request/response channel and the decode-side instruction channel.
// master = fetch unit, slave = instruction memory plus decode.
interface mig2_fetch_unit_if
  import mig2_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;

  logic                  insn_valid;
  logic                  insn_ready;
  logic [ADDR_WIDTH-1:0] insn_pc;
  logic [DATA_WIDTH-1:0] insn_data;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output insn_valid, insn_pc, insn_data,
    input  insn_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  insn_valid, insn_pc, insn_data,
    output insn_ready
  );

endinterface

// File: rtl/mig2_fetch_fifo.sv
// Flushable synchronous FIFO of fetch entries; registered storage, head visible the cycle after push.
// Flush wins over push/pop; push+pop together is legal even when full.
module mig2_fetch_fifo
  import mig2_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 4,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  entry_t           i_push_dat,
  input  logic             i_pop,
  output logic             o_head_vld,
  output entry_t           o_head_dat,
  output logic [CNT_W-1:0] o_occ
);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push && !i_flush && !rst;
  assign w_do_pop  = i_pop && !i_flush && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // When full, the write slot equals the head slot; the head is consumed this cycle so overwrite is safe.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head_vld = (r_cnt != '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_occ      = r_cnt;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_flush && !i_pop && (r_cnt == CNT_W'(DEPTH))));

endmodule

// File: rtl/mig2_fetch_unit.sv
// Mig2 fetch front end: credit-limited request issue, in-order response capture, redirect squash, halt.
// Response reaches insn_valid one cycle after mem_rsp_valid; issue stalls when queue credits run out.
module mig2_fetch_unit
  import mig2_pkg::*;
#(
  parameter int  ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int  DATA_SIZE       = DEF_DATA_SIZE,
  parameter int  FQ_DEPTH        = 4,
  parameter int  MAX_OUTSTANDING = 2,
  localparam int DATA_WIDTH      = DATA_SIZE * 8,
  localparam int WORD_LSB        = $clog2(DATA_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-WORD_LSB-1:0] rst_addr,
  mig2_fetch_unit_if.master            bus,
  input  logic                         redir_valid,
  input  logic [ADDR_WIDTH-1:0]        redir_addr,
  input  logic                         halt,
  output logic                         halted,
  output logic [ADDR_WIDTH-1:0]        debug_pc
);

  localparam int CNT_W = $clog2(FQ_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(DATA_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_SIZE - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] insn;
  } entry_t;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_rsp_pc;
  logic [CNT_W-1:0]      r_outstanding;
  logic [CNT_W-1:0]      r_drop_cnt;
  logic                  r_halted;

  logic [ADDR_WIDTH-1:0] w_rst_pc;
  logic [ADDR_WIDTH-1:0] w_redir_pc;
  logic [CNT_W-1:0]      w_occ;
  logic [CNT_W:0]        w_credit_used;
  logic [CNT_W-1:0]      w_out_nxt;
  logic                  w_issue;
  logic                  w_fire;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head_vld;
  entry_t                w_head;
  entry_t                w_push_dat;

  assign w_rst_pc   = {rst_addr, {WORD_LSB{1'b0}}};
  assign w_redir_pc = redir_addr & ALIGN_MASK;

  // Queue slots already filled plus slots promised to in-flight reads must leave room for one more.
  assign w_credit_used = {1'b0, w_occ} + {1'b0, r_outstanding};
  assign w_issue = !rst && !halt && !redir_valid
                && (r_outstanding < CNT_W'(MAX_OUTSTANDING))
                && (w_credit_used < (CNT_W+1)'(FQ_DEPTH));
  assign w_fire  = w_issue && bus.mem_req_ready;

  assign w_push     = bus.mem_rsp_valid && !rst && !redir_valid && (r_drop_cnt == '0);
  assign w_pop      = w_head_vld && bus.insn_ready;
  assign w_push_dat = {r_rsp_pc, bus.mem_rsp_data};
  assign w_out_nxt  = r_outstanding + CNT_W'(w_fire) - CNT_W'(bus.mem_rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= w_rst_pc;
      r_rsp_pc      <= w_rst_pc;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_halted      <= 1'b0;
    end else begin
      r_outstanding <= w_out_nxt;
      r_halted      <= halt && (w_out_nxt == '0);
      if (redir_valid) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_pc       <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
        r_drop_cnt <= r_outstanding - CNT_W'(bus.mem_rsp_valid);
      end else begin
        if (w_fire) r_pc     <= r_pc + STEP;
        if (w_push) r_rsp_pc <= r_rsp_pc + STEP;
        if (bus.mem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
    end
  end

  mig2_fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FQ_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (redir_valid),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_vld (w_head_vld),
    .o_head_dat (w_head),
    .o_occ      (w_occ)
  );

  assign bus.mem_req_valid = w_issue;
  assign bus.mem_req_addr  = r_pc;
  assign bus.insn_valid    = w_head_vld;
  assign bus.insn_pc       = w_head_vld ? w_head.pc   : '0;
  assign bus.insn_data     = w_head_vld ? w_head.insn : '0;
  assign halted            = r_halted;
  assign debug_pc          = r_pc;

endmodule

// File: tb/tb_mig2_fetch_unit.sv
// Directed bench for mig2_fetch_unit with an in-order memory model of configurable latency.
module tb_mig2_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] rst_addr = '0;
  logic       redir_valid = 1'b0;
  logic [7:0] redir_addr = '0;
  logic       halt = 1'b0;
  logic       halted;
  logic [7:0] debug_pc;

  always #5 clk = ~clk;

  mig2_fetch_unit_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  mig2_fetch_unit #(
    .ADDR_WIDTH(8), .DATA_SIZE(4), .FQ_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst), .rst_addr(rst_addr), .bus(bus),
    .redir_valid(redir_valid), .redir_addr(redir_addr),
    .halt(halt), .halted(halted), .debug_pc(debug_pc)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  bit zl = 1'b0;
  int lat = 1;
  int cyc = 0;

  logic [7:0]  req_q[$];
  logic [7:0]  pop_pc_q[$];
  logic [31:0] pop_dat_q[$];
  logic [7:0]  pend_addr[$];
  int          pend_due[$];
  logic        q_rsp_vld = 1'b0;
  logic [31:0] q_rsp_dat = '0;

  function automatic logic [31:0] data_of(input logic [7:0] a);
    return {8'hC3, 8'h5A, ~a, a};
  endfunction

  assign bus.mem_rsp_valid = zl ? (bus.mem_req_valid && bus.mem_req_ready) : q_rsp_vld;
  assign bus.mem_rsp_data  = zl ? data_of(bus.mem_req_addr) : q_rsp_dat;

  always @(posedge clk) begin
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (!zl && q_rsp_vld && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        req_q.push_back(bus.mem_req_addr);
        if (!zl) begin
          pend_addr.push_back(bus.mem_req_addr);
          pend_due.push_back(cyc + lat);
        end
      end
      if (bus.insn_valid && bus.insn_ready && !redir_valid) begin
        pop_pc_q.push_back(bus.insn_pc);
        pop_dat_q.push_back(bus.insn_data);
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (!zl && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      q_rsp_vld = 1'b1;
      q_rsp_dat = data_of(pend_addr[0]);
    end else begin
      q_rsp_vld = 1'b0;
      q_rsp_dat = '0;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic [5:0] ra, input bit z, input int l, input logic rdy);
    rst = 1'b1; rst_addr = ra; zl = z; lat = l;
    bus.insn_ready = rdy; bus.mem_req_ready = 1'b1;
    redir_valid = 1'b0; redir_addr = '0; halt = 1'b0;
    nxt(); nxt(); nxt();
    req_q.delete(); pop_pc_q.delete(); pop_dat_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b1; rst_addr = 6'h04; zl = 1'b1; lat = 0;
    bus.insn_ready = 1'b1; bus.mem_req_ready = 1'b1;
    redir_valid = 1'b0; halt = 1'b0;
    nxt(); nxt(); smp();
    total_cnt++; if (bus.mem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", bus.mem_req_valid); else pass_cnt++;
    total_cnt++; if (bus.insn_valid !== 1'b0) $display("FAIL rst_insn_valid: got %b want 0", bus.insn_valid); else pass_cnt++;
    total_cnt++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else pass_cnt++;
    total_cnt++; if (debug_pc !== 8'h10) $display("FAIL rst_debug_pc: got %h want 10", debug_pc); else pass_cnt++;
    total_cnt++; if (bus.insn_pc !== 8'h00) $display("FAIL rst_insn_pc: got %h want 00", bus.insn_pc); else pass_cnt++;
    total_cnt++; if (bus.insn_data !== 32'h0) $display("FAIL rst_insn_data: got %h want 0", bus.insn_data); else pass_cnt++;
    nxt();
    req_q.delete(); pop_pc_q.delete(); pop_dat_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      if (i < 3) begin
        e = 8'h10 + 8'(4 * i);
        total_cnt++;
        if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, e})
          $display("FAIL zl_req%0d: got %b/%h want 1/%h", i, bus.mem_req_valid, bus.mem_req_addr, e);
        else pass_cnt++;
      end
      if (i == 0) begin
        total_cnt++; if (bus.insn_valid !== 1'b0) $display("FAIL zl_latency: got insn_valid %b want 0", bus.insn_valid); else pass_cnt++;
      end else begin
        e = 8'h10 + 8'(4 * (i - 1));
        total_cnt++;
        if ({bus.insn_valid, bus.insn_pc} !== {1'b1, e})
          $display("FAIL zl_pc%0d: got %b/%h want 1/%h", i, bus.insn_valid, bus.insn_pc, e);
        else pass_cnt++;
        total_cnt++;
        if (bus.insn_data !== data_of(e)) $display("FAIL zl_data%0d: got %h want %h", i, bus.insn_data, data_of(e));
        else pass_cnt++;
      end
      nxt();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e;
    apply_reset(6'h00, 1'b0, 1, 1'b0);
    repeat (10) nxt();
    smp();
    total_cnt++; if (req_q.size() != 4) $display("FAIL bp_req_count: got %0d want 4", req_q.size()); else pass_cnt++;
    total_cnt++; if (bus.mem_req_valid !== 1'b0) $display("FAIL bp_stall: got %b want 0", bus.mem_req_valid); else pass_cnt++;
    total_cnt++; if ({bus.insn_valid, bus.insn_pc} !== 9'h100) $display("FAIL bp_head: got %b/%h want 1/00", bus.insn_valid, bus.insn_pc); else pass_cnt++;
    nxt();
    bus.insn_ready = 1'b1;
    repeat (12) nxt();
    total_cnt++;
    if (pop_pc_q.size() < 5 || req_q.size() < 5) begin
      $display("FAIL bp_drain_count: got pops %0d reqs %0d want >=5 each", pop_pc_q.size(), req_q.size());
    end else begin
      pass_cnt++;
      for (int i = 0; i < 5; i++) begin
        e = 8'(4 * i);
        total_cnt++;
        if (pop_pc_q[i] !== e || pop_dat_q[i] !== data_of(e))
          $display("FAIL bp_order%0d: got %h/%h want %h/%h", i, pop_pc_q[i], pop_dat_q[i], e, data_of(e));
        else pass_cnt++;
      end
      total_cnt++; if (req_q[4] !== 8'h10) $display("FAIL bp_resume: got %h want 10", req_q[4]); else pass_cnt++;
    end
  endtask

  task automatic test_redirect_squash();
    apply_reset(6'h08, 1'b0, 3, 1'b1);
    nxt(); nxt();
    redir_valid = 1'b1; redir_addr = 8'h83;
    smp();
    total_cnt++;
    if (req_q.size() != 2 || req_q[0] !== 8'h20 || req_q[1] !== 8'h24)
      $display("FAIL sq_inflight: got %0d reqs want 2 (20,24)", req_q.size());
    else pass_cnt++;
    total_cnt++; if (bus.mem_req_valid !== 1'b0) $display("FAIL sq_no_issue: got %b want 0", bus.mem_req_valid); else pass_cnt++;
    nxt();
    redir_valid = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      smp();
      total_cnt++; if (bus.insn_valid !== 1'b0) $display("FAIL sq_empty_c%0d: got %b want 0", c, bus.insn_valid); else pass_cnt++;
      if (c == 4) begin
        total_cnt++;
        if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, 8'h80})
          $display("FAIL sq_new_req: got %b/%h want 1/80", bus.mem_req_valid, bus.mem_req_addr);
        else pass_cnt++;
      end
      nxt();
    end
    repeat (10) nxt();
    total_cnt++;
    if (pop_pc_q.size() < 2) $display("FAIL sq_pop_count: got %0d want >=2", pop_pc_q.size());
    else if (pop_pc_q[0] !== 8'h80 || pop_dat_q[0] !== data_of(8'h80) || pop_pc_q[1] !== 8'h84)
      $display("FAIL sq_first_insn: got %h/%h,%h want 80/%h,84", pop_pc_q[0], pop_dat_q[0], pop_pc_q[1], data_of(8'h80));
    else pass_cnt++;
  endtask

  task automatic test_redirect_collide();
    int stale;
    apply_reset(6'h10, 1'b0, 2, 1'b0);
    repeat (5) nxt();
    redir_valid = 1'b1; redir_addr = 8'hA0; bus.insn_ready = 1'b1;
    smp();
    total_cnt++; if ({bus.insn_valid, bus.insn_pc} !== {1'b1, 8'h40}) $display("FAIL col_head: got %b/%h want 1/40", bus.insn_valid, bus.insn_pc); else pass_cnt++;
    total_cnt++; if (req_q.size() != 4) $display("FAIL col_req_count: got %0d want 4", req_q.size()); else pass_cnt++;
    total_cnt++; if (bus.mem_req_valid !== 1'b0) $display("FAIL col_no_issue: got %b want 0", bus.mem_req_valid); else pass_cnt++;
    nxt();
    redir_valid = 1'b0;
    smp();
    total_cnt++; if (bus.insn_valid !== 1'b0) $display("FAIL col_flushed: got %b want 0", bus.insn_valid); else pass_cnt++;
    total_cnt++;
    if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, 8'hA0})
      $display("FAIL col_new_req: got %b/%h want 1/a0", bus.mem_req_valid, bus.mem_req_addr);
    else pass_cnt++;
    for (int c = 7; c <= 8; c++) begin
      nxt(); smp();
      total_cnt++; if (bus.insn_valid !== 1'b0) $display("FAIL col_empty_c%0d: got %b want 0", c, bus.insn_valid); else pass_cnt++;
    end
    repeat (10) nxt();
    total_cnt++;
    if (pop_pc_q.size() < 2) $display("FAIL col_pop_count: got %0d want >=2", pop_pc_q.size());
    else if (pop_pc_q[0] !== 8'hA0 || pop_dat_q[0] !== data_of(8'hA0) || pop_pc_q[1] !== 8'hA4)
      $display("FAIL col_first_insn: got %h/%h,%h want a0/%h,a4", pop_pc_q[0], pop_dat_q[0], pop_pc_q[1], data_of(8'hA0));
    else pass_cnt++;
    stale = 0;
    foreach (pop_pc_q[i]) if (pop_pc_q[i] >= 8'h40 && pop_pc_q[i] <= 8'h4C) stale++;
    total_cnt++; if (stale != 0) $display("FAIL col_stale: got %0d stale entries want 0", stale); else pass_cnt++;
  endtask

  task automatic test_wrap_halt();
    apply_reset(6'h3F, 1'b0, 2, 1'b1);
    smp();
    total_cnt++; if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, 8'hFC}) $display("FAIL wrap_fc: got %b/%h want 1/fc", bus.mem_req_valid, bus.mem_req_addr); else pass_cnt++;
    nxt(); smp();
    total_cnt++; if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, 8'h00}) $display("FAIL wrap_00: got %b/%h want 1/00", bus.mem_req_valid, bus.mem_req_addr); else pass_cnt++;
    nxt();
    halt = 1'b1;
    smp();
    total_cnt++; if (halted !== 1'b0) $display("FAIL halt_c2: got %b want 0", halted); else pass_cnt++;
    nxt(); smp();
    total_cnt++; if (halted !== 1'b0) $display("FAIL halt_c3: got %b want 0", halted); else pass_cnt++;
    nxt(); smp();
    total_cnt++; if (halted !== 1'b1) $display("FAIL halt_c4: got %b want 1", halted); else pass_cnt++;
    total_cnt++; if (bus.mem_req_valid !== 1'b0) $display("FAIL halt_no_issue: got %b want 0", bus.mem_req_valid); else pass_cnt++;
    total_cnt++; if (debug_pc !== 8'h04) $display("FAIL halt_debug_pc: got %h want 04", debug_pc); else pass_cnt++;
    nxt(); smp();
    total_cnt++; if (req_q.size() != 2) $display("FAIL halt_req_count: got %0d want 2", req_q.size()); else pass_cnt++;
    nxt();
    halt = 1'b0;
    smp();
    total_cnt++; if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, 8'h04}) $display("FAIL halt_resume: got %b/%h want 1/04", bus.mem_req_valid, bus.mem_req_addr); else pass_cnt++;
    nxt(); smp();
    total_cnt++; if (halted !== 1'b0) $display("FAIL halt_release: got %b want 0", halted); else pass_cnt++;
    repeat (4) nxt();
    total_cnt++;
    if (pop_pc_q.size() < 2) $display("FAIL halt_drain_count: got %0d want >=2", pop_pc_q.size());
    else if (pop_pc_q[0] !== 8'hFC || pop_dat_q[0] !== data_of(8'hFC) || pop_pc_q[1] !== 8'h00 || pop_dat_q[1] !== data_of(8'h00))
      $display("FAIL halt_drain: got %h/%h,%h/%h want fc,00", pop_pc_q[0], pop_dat_q[0], pop_pc_q[1], pop_dat_q[1]);
    else pass_cnt++;
  endtask

  initial begin
    bus.mem_req_ready = 1'b1;
    bus.insn_ready = 1'b1;
    test_reset();
    test_backpressure();
    test_redirect_squash();
    test_redirect_collide();
    test_wrap_halt();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
